// File: rtl/sprite_pixel_fetch.sv
// sprite_pixel_fetch
//   Looks up the 16x16 player sprite ROM for each scan pixel and merges the
//   returned colour over the background. Pixel-to-output latency is 2 clocks
//   (address in cycle n, ROM data in n+1, registered colour after n+1).
//
//   Optional build macro: SPRITE_BLINK_EN
//     When defined, a 4-bit frame counter hides the sprite for 8 of every 16
//     frames while 'hurt' is high. Otherwise 'hurt' is ignored.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   x, y            current scan pixel
//   video_on        pixel is in the visible area
//   frame_tick      start-of-vblank pulse; latches the sprite position
//   sprite_x/y      requested sprite top-left corner
//   face_left       mirror the sprite horizontally
//   hurt            player-hurt flag (blink build only)
//   bg_rgb          background colour, aligned with x/y
//   rom_row/col     ROM address (bit 4 always 0)
//   rom_data        ROM colour, one cycle after the address
//   rgb_out         final pixel colour
//   sprite_opaque   rgb_out came from a non-transparent sprite pixel
module sprite_pixel_fetch #(
    parameter int          X_W         = 10,
    parameter int          Y_W         = 10,
    parameter int          SPRITE_SIZE = 16,
    parameter logic [11:0] TRANS_COLOR = 12'hFFF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  logic           video_on,
    input  logic           frame_tick,
    input  logic [X_W-1:0] sprite_x,
    input  logic [Y_W-1:0] sprite_y,
    input  logic           face_left,
    input  logic           hurt,
    input  logic [11:0]    bg_rgb,
    output logic [4:0]     rom_row,
    output logic [4:0]     rom_col,
    input  logic [11:0]    rom_data,
    output logic [11:0]    rgb_out,
    output logic           sprite_opaque
);

    localparam logic [X_W:0] SIZE_X = (X_W+1)'(SPRITE_SIZE);
    localparam logic [Y_W:0] SIZE_Y = (Y_W+1)'(SPRITE_SIZE);

    logic [X_W-1:0] spx_q;
    logic [Y_W-1:0] spy_q;
    logic           flip_q;

    logic [X_W:0]   dx;
    logic [Y_W:0]   dy;
    logic           in_box;
    logic           hidden;
    logic           hit0;

    logic           hit1;
    logic           von1;
    logic [11:0]    bg1;
    logic           opaque;

    // Position is only sampled at vblank so the sprite never tears mid-frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            spx_q  <= '0;
            spy_q  <= '0;
            flip_q <= 1'b0;
        end else if (frame_tick) begin
            spx_q  <= sprite_x;
            spy_q  <= sprite_y;
            flip_q <= face_left;
        end
    end

    // One extra bit on the subtraction: a pixel left of/above the sprite
    // sets the top bit, so a sprite near the screen edge cannot wrap round.
    assign dx     = {1'b0, x} - {1'b0, spx_q};
    assign dy     = {1'b0, y} - {1'b0, spy_q};
    assign in_box = !dx[X_W] && (dx < SIZE_X) && !dy[Y_W] && (dy < SIZE_Y);

`ifdef SPRITE_BLINK_EN
    logic [3:0] blink_cnt;

    always_ff @(posedge clk) begin
        if (reset || !hurt) begin
            blink_cnt <= '0;
        end else if (frame_tick) begin
            blink_cnt <= blink_cnt + 4'd1;
        end
    end

    assign hidden = hurt && blink_cnt[3];
`else
    logic unused_hurt;
    assign unused_hurt = hurt;
    assign hidden      = 1'b0;
`endif

    assign hit0    = in_box && !hidden;
    assign rom_row = {1'b0, dy[3:0]};
    assign rom_col = {1'b0, flip_q ? ~dx[3:0] : dx[3:0]};

    // Stage 1: line the hit/blanking/background up with the ROM's data.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit1 <= 1'b0;
            von1 <= 1'b0;
            bg1  <= '0;
        end else begin
            hit1 <= hit0;
            von1 <= video_on;
            bg1  <= bg_rgb;
        end
    end

    assign opaque = hit1 && (rom_data != TRANS_COLOR);

    // Stage 2: registered colour merge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_out       <= '0;
            sprite_opaque <= 1'b0;
        end else begin
            rgb_out       <= !von1 ? 12'h000 : (opaque ? rom_data : bg1);
            sprite_opaque <= von1 && opaque;
        end
    end

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
module tb_sprite_pixel_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x, y, sprite_x, sprite_y;
    logic        video_on, frame_tick, face_left, hurt;
    logic [11:0] bg_rgb, rom_data, rgb_out;
    logic [4:0]  rom_row, rom_col;
    logic        sprite_opaque;

    logic [11:0] rom_mem [256];

    typedef struct {
        int          due;
        logic [11:0] rgb;
        logic        opq;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference state: what the block should have latched so far.
    int m_spx   = 0;
    int m_spy   = 0;
    bit m_flip  = 1'b0;
    int m_blink = 0;

    sprite_pixel_fetch dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on),
        .frame_tick(frame_tick), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .face_left(face_left), .hurt(hurt), .bg_rgb(bg_rgb),
        .rom_row(rom_row), .rom_col(rom_col), .rom_data(rom_data),
        .rgb_out(rgb_out), .sprite_opaque(sprite_opaque)
    );

    always #5 clk = ~clk;

    // Sprite ROM with a registered address.
    always @(posedge clk) rom_data <= rom_mem[{rom_row[3:0], rom_col[3:0]}];

    // Monitor: every cycle the DUT presents a pixel; compare any due entry.
    always @(posedge clk) begin : monitor
        exp_t e;
        cyc++;
        #1;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            total++;
            if (rgb_out !== e.rgb) begin
                bad++;
                $display("FAIL rgb_out cyc=%0d got=%h expected=%h", cyc, rgb_out, e.rgb);
            end
            total++;
            if (sprite_opaque !== e.opq) begin
                bad++;
                $display("FAIL sprite_opaque cyc=%0d got=%0b expected=%0b", cyc, sprite_opaque, e.opq);
            end
        end
    end

    // Apply the current inputs for one cycle: check the ROM address, push the
    // expected pixel, advance the reference state, and move to the next negedge.
    task automatic step();
        int          dxi, dyi, row, col;
        bit          inb, hid, opq;
        logic [11:0] er, colour;
        logic        eo;
        exp_t        prev;
        #1;
        dxi = int'(x) - m_spx;
        dyi = int'(y) - m_spy;
        inb = (dxi >= 0) && (dxi < 16) && (dyi >= 0) && (dyi < 16);
        row = dyi;
        col = m_flip ? 15 - dxi : dxi;
        colour = 12'hFFF;
        if (inb) begin
            colour = rom_mem[row * 16 + col];
            total++;
            if (rom_row !== 5'(row) || rom_col !== 5'(col)) begin
                bad++;
                $display("FAIL rom_addr cyc=%0d got row=%0d col=%0d expected row=%0d col=%0d",
                         cyc, rom_row, rom_col, row, col);
            end
        end
`ifdef SPRITE_BLINK_EN
        hid = hurt && (m_blink >= 8);
`else
        hid = 1'b0;
`endif
        opq = inb && !hid && (colour != 12'hFFF);
        er  = !video_on ? 12'h000 : (opq ? colour : bg_rgb);
        eo  = video_on && opq;
        if (reset) begin
            er = 12'h000;
            eo = 1'b0;
            // The previous pixel is still in flight and gets flushed too.
            if (sb.size() > 0 && sb[sb.size()-1].due == cyc + 1) begin
                prev = sb.pop_back();
                prev.rgb = 12'h000;
                prev.opq = 1'b0;
                sb.push_back(prev);
            end
        end
        sb.push_back('{cyc + 2, er, eo});
        if (reset) begin
            m_spx = 0; m_spy = 0; m_flip = 1'b0; m_blink = 0;
        end else begin
            if (frame_tick) begin
                m_spx = int'(sprite_x); m_spy = int'(sprite_y); m_flip = face_left;
            end
            if (!hurt)           m_blink = 0;
            else if (frame_tick) m_blink = (m_blink + 1) % 16;
        end
        @(negedge clk);
    endtask

    task automatic px(input int xi, input int yi);
        x = 10'(xi); y = 10'(yi);
        frame_tick = 1'b0;
        bg_rgb = 12'($urandom);
        step();
    endtask

    task automatic tick(input int sx, input int sy, input bit fl);
        sprite_x = 10'(sx); sprite_y = 10'(sy); face_left = fl;
        frame_tick = 1'b1;
        x = 10'd600; y = 10'd400;
        step();
        frame_tick = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            rom_mem[i] = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
        rom_mem[0] = 12'hFFF;
        rom_mem[3] = 12'h666;

        reset = 1'b1; video_on = 1'b1; frame_tick = 1'b0; face_left = 1'b0; hurt = 1'b0;
        x = '0; y = '0; sprite_x = '0; sprite_y = '0; bg_rgb = 12'h123;
        repeat (3) step();

        // Background only, away from the sprite at (0,0).
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            x = 10'(500 + i); y = 10'd400; bg_rgb = 12'h123;
            step();
        end

        // Basic hits, transparency and edges.
        tick(100, 50, 1'b0);
        px(100, 50); px(103, 50); px(108, 57); px(115, 65); px(116, 50); px(99, 50); px(100, 66);

        // Mirrored.
        tick(100, 50, 1'b1);
        px(100, 50); px(115, 65); px(116, 50); px(103, 50);

        // Position change without vblank must not move the sprite.
        tick(100, 50, 1'b0);
        sprite_x = 10'd200;
        px(100, 50); px(200, 50);
        frame_tick = 1'b1; x = 10'd103; y = 10'd50; bg_rgb = 12'h0A5;
        step();
        frame_tick = 1'b0;
        px(103, 50); px(203, 50);

        // Right-edge clipping with no wrap to x=0.
        tick(1020, 50, 1'b0);
        px(1023, 50); px(2, 50); px(1020, 50);
        video_on = 1'b0; px(1023, 50); px(1021, 51); video_on = 1'b1;

        // Reset in the middle of hits.
        tick(100, 50, 1'b0);
        px(103, 50);
        reset = 1'b1; px(103, 50); px(104, 51);
        reset = 1'b0; px(3, 0); px(103, 50); px(4, 1);

`ifdef SPRITE_BLINK_EN
        tick(100, 50, 1'b0);
        hurt = 1'b1;
        for (int f = 0; f < 18; f++) begin
            tick(100, 50, 1'b0);
            px(103, 50); px(105, 55);
        end
        hurt = 1'b0;
        px(103, 50); px(105, 55);
`endif

        // Randomized traffic concentrated around the sprite.
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            frame_tick = ($urandom_range(0, 19) == 0);
            if (frame_tick) begin
                sprite_x  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1008, 1023)) : 10'($urandom);
                sprite_y  = 10'($urandom);
                face_left = 1'($urandom);
            end
            if ($urandom_range(0, 49) == 0) hurt = ~hurt;
            video_on = ($urandom_range(0, 9) != 0);
            bg_rgb   = 12'($urandom);
            if ($urandom_range(0, 4) != 0) begin
                x = 10'(m_spx + $urandom_range(0, 24) - 4);
                y = 10'(m_spy + $urandom_range(0, 24) - 4);
            end else begin
                x = 10'($urandom);
                y = 10'($urandom);
            end
            step();
        end
        reset = 1'b0; frame_tick = 1'b0;

        for (int i = 0; i < 10 && sb.size() > 0; i++) px(700, 700);
        repeat (3) @(negedge clk);
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
